// File: rtl/coord_entry_pkg.sv
// Shared types and default parameters for the coordinate entry unit.
package coord_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_X_ENTRY = 2'd1,
    ST_Y_ENTRY = 2'd2,
    ST_CONFIRM = 2'd3
  } state_e;

  localparam logic [1:0] PHASE_IDLE    = 2'd0;
  localparam logic [1:0] PHASE_X_ENTRY = 2'd1;
  localparam logic [1:0] PHASE_Y_ENTRY = 2'd2;
  localparam logic [1:0] PHASE_CONFIRM = 2'd3;

  localparam int unsigned DEF_COORD_W        = 4;
  localparam int unsigned DEF_GRID_MAX       = 9;
  localparam int unsigned DEF_DEB_CYCLES     = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1 << 20;

endpackage

// File: rtl/coord_entry_unit_button_conditioner.sv
// Synchronise, debounce and edge-detect one raw active-low button.
module button_conditioner #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  // Counter must reach DEB_CYCLES+1 for the post-reset arming window.
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 3);

  logic [1:0]       sync_q;
  logic             sync_lvl;
  logic             level_q, level_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             press_q, press_d;

  assign sync_lvl = sync_q[1];
  assign press_o  = press_q;

  // Debounce, arming and press detection; a button held through reset stays
  // disarmed until it has been seen released for a full debounce window.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;

    if (sync_lvl != level_q) begin
      if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync_lvl;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end

    if (!armed_q) begin
      if (!sync_lvl || !level_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == CNT_W'(DEB_CYCLES + 1)) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + CNT_W'(1);
      end
    end

    press_d = armed_q & level_q & ~level_d;
  end

  // Synchroniser and conditioner state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      level_q   <= 1'b1;
      deb_cnt_q <= '0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_n_i};
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      press_q   <= press_d;
    end
  end

endmodule

// File: rtl/coord_entry_unit.sv
// Three-button serial entry of an (x, y) grid coordinate with range check.
module coord_entry_unit
  import coord_entry_pkg::*;
#(
  parameter int unsigned COORD_W        = DEF_COORD_W,
  parameter int unsigned GRID_MAX       = DEF_GRID_MAX,
  parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         logic_0_button,
  input  logic                         logic_1_button,
  input  logic                         activity_button,
  output logic [COORD_W-1:0]           x_output,
  output logic [COORD_W-1:0]           y_output,
  output logic [$clog2(COORD_W+1)-1:0] bit_count,
  output logic [1:0]                   phase,
  output logic                         valid_coordinate,
  output logic                         coord_error,
  output logic                         entry_timeout
);

  localparam int unsigned CNT_W = $clog2(COORD_W + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               valid_q, valid_d, err_q, err_d, tout_q, tout_d;

  logic ev0, ev1, eva;
  logic bit_ev, any_ev, cnt_full, tmo_hit, in_range;

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn0 (
    .clk(clk), .reset(reset), .btn_n_i(logic_0_button), .press_o(ev0)
  );
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn1 (
    .clk(clk), .reset(reset), .btn_n_i(logic_1_button), .press_o(ev1)
  );
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btna (
    .clk(clk), .reset(reset), .btn_n_i(activity_button), .press_o(eva)
  );

  // Simultaneous 0 and 1 presses cancel out; the bit value is simply ev1.
  assign bit_ev   = ev0 ^ ev1;
  assign any_ev   = ev0 | ev1 | eva;
  assign cnt_full = (cnt_q == CNT_W'(COORD_W));
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !any_ev;
  assign in_range = (x_q <= COORD_W'(GRID_MAX)) && (y_q <= COORD_W'(GRID_MAX));

  assign x_output         = x_q;
  assign y_output         = y_q;
  assign bit_count        = cnt_q;
  assign phase            = state_q;
  assign valid_coordinate = valid_q;
  assign coord_error      = err_q;
  assign entry_timeout    = tout_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic; cancel and timeout win over axis completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bit_ev) state_d = ST_X_ENTRY;
      ST_X_ENTRY: if (eva || tmo_hit) state_d = ST_IDLE;
                  else if (cnt_full) state_d = ST_Y_ENTRY;
      ST_Y_ENTRY: if (eva || tmo_hit) state_d = ST_IDLE;
                  else if (cnt_full) state_d = ST_CONFIRM;
      ST_CONFIRM: if (eva || tmo_hit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and pulse outputs for the current state.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    tmo_d   = any_ev ? '0 : tmo_q + TMO_W'(1);
    valid_d = 1'b0;
    err_d   = 1'b0;
    tout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (bit_ev) begin
          x_d   = {ev1, (COORD_W-1)'(0)};
          y_d   = '0;
          cnt_d = CNT_W'(1);
        end
      end
      ST_X_ENTRY, ST_Y_ENTRY: begin
        if (eva || tmo_hit) begin
          x_d    = '0;
          y_d    = '0;
          cnt_d  = '0;
          tout_d = tmo_hit;
        end else if (cnt_full) begin
          if (state_q == ST_X_ENTRY) cnt_d = '0;
        end else if (bit_ev) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_X_ENTRY) x_d = {ev1, x_q[COORD_W-1:1]};
          else                       y_d = {ev1, y_q[COORD_W-1:1]};
        end
      end
      ST_CONFIRM: begin
        if (eva) begin
          valid_d = in_range;
          err_d   = !in_range;
        end else if (tmo_hit) begin
          x_d    = '0;
          y_d    = '0;
          cnt_d  = '0;
          tout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coord_entry_unit.sv
// Directed bench for coord_entry_unit with short debounce and timeout.
module tb_coord_entry_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b0 = 1'b1, b1 = 1'b1, ba = 1'b1;
  logic [3:0] xo, yo;
  logic [2:0] bc;
  logic [1:0] ph;
  logic       vld, err, tmo;

  int n_total = 0;
  int n_bad   = 0;
  int n_vld = 0, n_err = 0, n_tmo = 0, n_viol = 0;
  logic prev_pulse = 1'b0;
  int sv, se, st;

  coord_entry_unit #(
    .COORD_W(4), .GRID_MAX(9), .DEB_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .logic_0_button(b0), .logic_1_button(b1), .activity_button(ba),
    .x_output(xo), .y_output(yo), .bit_count(bc), .phase(ph),
    .valid_coordinate(vld), .coord_error(err), .entry_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Pulse counters plus exclusivity / back-to-back watch.
  always @(negedge clk) begin
    n_vld = n_vld + int'(vld);
    n_err = n_err + int'(err);
    n_tmo = n_tmo + int'(tmo);
    if ((int'(vld) + int'(err) + int'(tmo)) > 1) n_viol++;
    if ((vld | err | tmo) && prev_pulse) n_viol++;
    prev_pulse = vld | err | tmo;
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: b0 = v;
      1: b1 = v;
      default: ba = v;
    endcase
  endtask

  // which: 0, 1, 2=activity, 3=both 0 and 1 together.
  task automatic press(input int which);
    @(posedge clk); #1;
    if (which == 3) begin b0 = 1'b0; b1 = 1'b0; end else drive(which, 1'b0);
    tick(10); #1;
    b0 = 1'b1; b1 = 1'b1; ba = 1'b1;
    tick(10);
  endtask

  task automatic glitch(input int lo, input int hi);
    @(posedge clk); #1 b1 = 1'b0;
    tick(lo); #1 b1 = 1'b1;
    tick(hi);
  endtask

  task automatic snap();
    sv = n_vld; se = n_err; st = n_tmo;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    tick(3); #1 reset = 1'b0;
    tick(20);
  endtask

  initial begin
    int got, k;
    tick(4);
    @(negedge clk);
    chk("rst_phase", ph, 0);
    chk("rst_x", xo, 0);
    chk("rst_y", yo, 0);
    chk("rst_bc", bc, 0);
    chk("rst_pulses", int'(vld) + int'(err) + int'(tmo), 0);
    #1 reset = 1'b0;
    tick(20);

    // x = 1,0,0,1 -> 1001 ; y = 0,1,1,0 -> 0110 ; confirm -> valid
    snap();
    press(1);
    chk("x1_phase", ph, 1);
    chk("x1_bc", bc, 1);
    chk("x1_x", xo, 8);
    press(0); press(0); press(1);
    chk("x4_phase", ph, 2);
    chk("x4_bc", bc, 0);
    chk("x4_x", xo, 9);
    press(0); press(1); press(1); press(0);
    chk("y4_phase", ph, 3);
    chk("y4_bc", bc, 4);
    chk("y4_y", yo, 6);
    press(2);
    chk("ok_valid", n_vld - sv, 1);
    chk("ok_err", n_err - se, 0);
    chk("ok_phase", ph, 0);
    chk("ok_x_hold", xo, 9);
    chk("ok_y_hold", yo, 6);

    // x = 15 out of range -> error
    snap();
    press(1); press(1); press(1); press(1);
    press(0); press(1); press(0); press(0);
    chk("oor_x", xo, 15);
    chk("oor_y", yo, 2);
    press(2);
    chk("oor_err", n_err - se, 1);
    chk("oor_valid", n_vld - sv, 0);
    chk("oor_phase", ph, 0);

    // bouncy 1 press yields exactly one bit, then cancel after 2 bits
    snap();
    press(0);
    chk("bnc_x0", xo, 0);
    chk("bnc_bc0", bc, 1);
    glitch(2, 2); glitch(3, 1); glitch(1, 3); glitch(3, 2);
    chk("bnc_glitch_bc", bc, 1);
    @(posedge clk); #1 b1 = 1'b0;
    tick(50); #1 b1 = 1'b1;
    tick(10);
    chk("bnc_bc", bc, 2);
    chk("bnc_x", xo, 8);
    press(2);
    chk("cxl_phase", ph, 0);
    chk("cxl_x", xo, 0);
    chk("cxl_bc", bc, 0);
    chk("cxl_pulses", (n_vld - sv) + (n_err - se) + (n_tmo - st), 0);

    // simultaneous 0/1 ignored, then reset during Y entry
    snap();
    press(1);
    press(3);
    chk("both_bc", bc, 1);
    chk("both_x", xo, 8);
    press(0); press(0); press(1);
    chk("both_x4", xo, 9);
    press(1);
    chk("ry_phase", ph, 2);
    chk("ry_y", yo, 8);
    @(posedge clk); #1 reset = 1'b1;
    tick(2);
    @(negedge clk);
    chk("ry_phase0", ph, 0);
    chk("ry_x0", xo, 0);
    chk("ry_y0", yo, 0);
    chk("ry_bc0", bc, 0);
    chk("ry_pulses", (n_vld - sv) + (n_err - se) + (n_tmo - st), 0);
    #1 reset = 1'b0;
    tick(20);

    // button held through reset must not produce an event
    @(posedge clk); #1 b1 = 1'b0;
    tick(10);
    do_reset();
    chk("held_phase", ph, 0);
    #1 b1 = 1'b1;
    tick(20);
    chk("held_rel_phase", ph, 0);

    // inactivity timeout after one bit
    snap();
    @(posedge clk); #1 b1 = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ph == 2'd1) begin got = 1; break; end
    end
    chk("tmo_enter", got, 1);
    k = 0;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k++;
      if (k == 10) b1 = 1'b1;
      if (tmo) begin got = 1; break; end
    end
    chk("tmo_seen", got, 1);
    chk("tmo_latency", k, 100);
    chk("tmo_phase", ph, 0);
    chk("tmo_x", xo, 0);
    tick(20);
    chk("tmo_once", n_tmo - st, 1);
    chk("tmo_no_valid", n_vld - sv, 0);
    chk("pulse_rules", n_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
